tim_apb_arb: RTL and testbench

Two-port APB master arbiter that shares the timer's single APB slave port between two requesters, for example a CPU bridge on port 0 and a DMA/sequencer on port 1. It arbitrates round-robin, runs the APB setup/access handshake with the timer, and returns read data and error status to the granted requester. It also aborts transfers whose slave never asserts pready. It sits directly in front of the timer's `tim_*` APB inputs.

---
 rtl/tim_apb_arb_pkg.sv | 19 +
 rtl/tim_apb_arb_if.sv | 36 +++
 rtl/tim_apb_arb_rr_arb2.sv | 44 ++++
 rtl/tim_apb_arb.sv | 162 ++++++++++++++++
 tb/tb_tim_apb_arb.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/tim_apb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tim_apb_pkg
//  Description : Shared constants for the timer APB arbiter: FSM state
//                encoding, default bus widths and requester index width.
//  Revision    : 1.0  initial release
// ============================================================================
package tim_apb_pkg;

    localparam int c_ADDR_W = 12;
    localparam int c_DATA_W = 32;
    localparam int c_IDX_W  = 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;

endpackage
`default_nettype wire

// File: rtl/tim_apb_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : tim_apb_arb_if
//  Description : APB bus bundle between the arbiter (master) and the timer
//                slave port.
//  Revision    : 1.0  initial release
// ============================================================================
interface tim_apb_arb_if
    import tim_apb_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) ();

    logic              tim_psel;
    logic              tim_penable;
    logic              tim_pwrite;
    logic [ADDR_W-1:0] tim_paddr;
    logic [DATA_W-1:0] tim_pwdata;
    logic [3:0]        tim_pstrb;
    logic              tim_pready;
    logic              tim_pslverr;
    logic [DATA_W-1:0] tim_prdata;

    modport master (
        output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
        input  tim_pready, tim_pslverr, tim_prdata
    );

    modport slave (
        input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
        output tim_pready, tim_pslverr, tim_prdata
    );

endinterface
`default_nettype wire

// File: rtl/tim_apb_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : tim_rr_arb2
//  Description : Two-way round-robin grant. Grant is combinational from the
//                eligible bits; the last-granted pointer is registered and
//                moves only on a grant strobe. Pointer resets to 1 so port 0
//                wins the first tie.
//  Revision    : 1.0  initial release
// ============================================================================
module tim_rr_arb2
    import tim_apb_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [1:0]         i_elig,
    input  wire logic               i_gnt_stb,
    output logic                    o_gnt_vld,
    output logic [c_IDX_W-1:0]      o_gnt_idx
);

    logic [c_IDX_W-1:0] r_last_gnt;

    // Pick the lone eligible port, or on a tie the one not granted last
    always_comb begin
        o_gnt_vld = |i_elig;
        o_gnt_idx = 1'b0;
        if (i_elig == 2'b10) begin
            o_gnt_idx = 1'b1;
        end else if (i_elig == 2'b11) begin
            o_gnt_idx = ~r_last_gnt;
        end
    end

    // Remember who won, so the other port takes the next tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= 1'b1;
        end else if (i_gnt_stb) begin
            r_last_gnt <= o_gnt_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tim_apb_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tim_apb_arb
//  Description : Shares the timer APB slave port between two requesters.
//                Round-robin grant, APB setup/access sequencing, return of
//                read data / error status, and abort of transfers whose
//                slave never raises pready.
//  Revision    : 1.0  initial release
// ============================================================================
module tim_apb_arb
    import tim_apb_pkg::*;
#(
    parameter int ADDR_W  = c_ADDR_W,
    parameter int DATA_W  = c_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  wire logic              sys_clk,
    input  wire logic              sys_rst,
    input  wire logic              req0,
    input  wire logic              req1,
    input  wire logic              write0,
    input  wire logic              write1,
    input  wire logic [ADDR_W-1:0] addr0,
    input  wire logic [ADDR_W-1:0] addr1,
    input  wire logic [DATA_W-1:0] wdata0,
    input  wire logic [DATA_W-1:0] wdata1,
    input  wire logic [3:0]        strb0,
    input  wire logic [3:0]        strb1,
    output logic                   ack0,
    output logic                   ack1,
    output logic [DATA_W-1:0]      rdata0,
    output logic [DATA_W-1:0]      rdata1,
    output logic                   err0,
    output logic                   err1,
    output logic                   busy,
    tim_apb_arb_if.master          tim_bus
);

    // Saturating wait counter; one extra bit keeps TIMEOUT-1 reachable
    localparam int c_CNT_W = $clog2(TIMEOUT) + 1;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_gnt_idx;
    logic [c_CNT_W-1:0] r_wait_cnt;

    logic [1:0]         w_elig;
    logic               w_gnt_vld;
    logic [c_IDX_W-1:0] w_gnt_idx;
    logic               w_gnt_stb;
    logic               w_sel_write;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic [3:0]         w_sel_strb;
    logic               w_tmo_hit;
    logic               w_complete;
    logic               w_done_err;
    logic               w_done_upd;
    logic [DATA_W-1:0]  w_done_rdata;

    // A port being acked this cycle is masked so its still-high req waits
    assign w_elig    = {req1 & ~ack1, req0 & ~ack0};
    assign w_gnt_stb = (r_state == c_ST_IDLE) && w_gnt_vld;

    tim_rr_arb2 u_rr (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .i_elig    (w_elig),
        .i_gnt_stb (w_gnt_stb),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_sel_write = w_gnt_idx[0] ? write1 : write0;
    assign w_sel_addr  = w_gnt_idx[0] ? addr1  : addr0;
    assign w_sel_wdata = w_gnt_idx[0] ? wdata1 : wdata0;
    assign w_sel_strb  = w_gnt_idx[0] ? strb1  : strb0;

    // pready has priority over a simultaneous timeout hit
    assign w_tmo_hit    = (TIMEOUT != 0) && (32'(r_wait_cnt) == 32'(TIMEOUT - 1));
    assign w_complete   = (r_state == c_ST_ACCESS) && (tim_bus.tim_pready || w_tmo_hit);
    assign w_done_err   = tim_bus.tim_pready ? tim_bus.tim_pslverr : 1'b1;
    assign w_done_rdata = tim_bus.tim_pready ? tim_bus.tim_prdata : '0;
    // Normal writes leave rdata alone; an abort always clears it
    assign w_done_upd   = tim_bus.tim_pready ? ~tim_bus.tim_pwrite : 1'b1;

    assign busy = (r_state != c_ST_IDLE);

    // Transfer FSM: grant, APB phase sequencing and wait counting
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state             <= c_ST_IDLE;
            r_gnt_idx           <= 1'b0;
            r_wait_cnt          <= '0;
            tim_bus.tim_psel    <= 1'b0;
            tim_bus.tim_penable <= 1'b0;
            tim_bus.tim_pwrite  <= 1'b0;
            tim_bus.tim_paddr   <= '0;
            tim_bus.tim_pwdata  <= '0;
            tim_bus.tim_pstrb   <= 4'h0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_gnt_stb) begin
                        r_gnt_idx           <= w_gnt_idx;
                        tim_bus.tim_pwrite  <= w_sel_write;
                        tim_bus.tim_paddr   <= w_sel_addr;
                        tim_bus.tim_pwdata  <= w_sel_write ? w_sel_wdata : '0;
                        tim_bus.tim_pstrb   <= w_sel_write ? w_sel_strb : 4'h0;
                        tim_bus.tim_psel    <= 1'b1;
                        tim_bus.tim_penable <= 1'b0;
                        r_state             <= c_ST_SETUP;
                    end
                end
                c_ST_SETUP: begin
                    tim_bus.tim_penable <= 1'b1;
                    r_wait_cnt          <= '0;
                    r_state             <= c_ST_ACCESS;
                end
                c_ST_ACCESS: begin
                    if (w_complete) begin
                        tim_bus.tim_psel    <= 1'b0;
                        tim_bus.tim_penable <= 1'b0;
                        r_state             <= c_ST_IDLE;
                    end else if (r_wait_cnt != {c_CNT_W{1'b1}}) begin
                        r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Return path: one-cycle ack plus held rdata/err for the granted port
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            if (w_complete) begin
                if (r_gnt_idx == 1'b0) begin
                    ack0 <= 1'b1;
                    err0 <= w_done_err;
                    if (w_done_upd) rdata0 <= w_done_rdata;
                end else begin
                    ack1 <= 1'b1;
                    err1 <= w_done_err;
                    if (w_done_upd) rdata1 <= w_done_rdata;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tim_apb_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tim_apb_arb
//  Description : Randomized bench for tim_apb_arb. A transaction-timeline
//                model predicts every cycle's bus controls, latched fields,
//                acks and returned data/error; the bench also plays both
//                requesters and the APB slave.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tim_apb_arb;
    import tim_apb_pkg::*;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;
    localparam int NCYC    = 3000;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [1:0]        req;
    logic [1:0]        wr;
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] wdata [2];
    logic [3:0]        strb  [2];
    logic              ack0, ack1, err0, err1, busy;
    logic [DATA_W-1:0] rdata0, rdata1;

    tim_apb_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    tim_apb_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req0    (req[0]),
        .req1    (req[1]),
        .write0  (wr[0]),
        .write1  (wr[1]),
        .addr0   (addr[0]),
        .addr1   (addr[1]),
        .wdata0  (wdata[0]),
        .wdata1  (wdata[1]),
        .strb0   (strb[0]),
        .strb1   (strb[1]),
        .ack0    (ack0),
        .ack1    (ack1),
        .rdata0  (rdata0),
        .rdata1  (rdata1),
        .err0    (err0),
        .err1    (err1),
        .busy    (busy),
        .tim_bus (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model: the current/last transfer as a timeline of cycle indices
    bit                active;
    int                g, ack_edge, w, port, last_gnt;
    bit                t_write;
    bit                done_err;
    logic [DATA_W-1:0] done_rdata;
    logic [48:0]       exp_fields;
    logic [DATA_W-1:0] exp_rdata [2];
    bit                exp_err   [2];
    bit                rst_prev;
    int                n_ack [2];
    int                n_tmo;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        active       = 1'b0;
        last_gnt     = 1;
        exp_fields   = '0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        exp_err[0]   = 1'b0;
        exp_err[1]   = 1'b0;
    endtask

    task automatic new_fields(input int p);
        wr[p]    = 1'($urandom_range(0, 1));
        addr[p]  = ADDR_W'($urandom);
        wdata[p] = $urandom;
        strb[p]  = 4'($urandom);
    endtask

    initial begin
        bit e_psel, e_pen, rst_now, el0, el1;
        bit e_ack [2];

        sys_rst         = 1'b1;
        req             = 2'b00;
        wr              = 2'b00;
        for (int p = 0; p < 2; p++) new_fields(p);
        bus.tim_pready  = 1'b0;
        bus.tim_pslverr = 1'b0;
        bus.tim_prdata  = '0;
        n_ack[0] = 0;
        n_ack[1] = 0;
        n_tmo    = 0;
        g        = 0;
        ack_edge = 0;
        w        = 0;
        port     = 0;
        t_write  = 1'b0;
        rst_prev = 1'b1;
        model_reset();

        repeat (3) @(posedge sys_clk);

        for (int c = 0; c < NCYC; c++) begin
            @(negedge sys_clk);
            cyc = c;

            // Outputs this cycle follow from the last edge
            if (rst_prev) begin
                model_reset();
            end else if (active && c == ack_edge) begin
                if (w < TIMEOUT) begin
                    exp_err[port] = done_err;
                    if (!t_write) exp_rdata[port] = done_rdata;
                end else begin
                    exp_err[port]   = 1'b1;
                    exp_rdata[port] = '0;
                    n_tmo++;
                end
                n_ack[port]++;
            end

            e_psel   = active && c >= g && c < ack_edge;
            e_pen    = active && c >= g + 1 && c < ack_edge;
            e_ack[0] = active && c == ack_edge && port == 0;
            e_ack[1] = active && c == ack_edge && port == 1;

            check_val("ctrl{psel,pen,busy,ack1,ack0}",
                      {bus.tim_psel, bus.tim_penable, busy, ack1, ack0},
                      {e_psel, e_pen, e_psel, e_ack[1], e_ack[0]});
            check_val("fields{pwrite,paddr,pwdata,pstrb}",
                      {bus.tim_pwrite, bus.tim_paddr, bus.tim_pwdata, bus.tim_pstrb},
                      exp_fields);
            check_val("rdata0", rdata0, exp_rdata[0]);
            check_val("rdata1", rdata1, exp_rdata[1]);
            check_val("err{1,0}", {err1, err0}, {exp_err[1], exp_err[0]});

            // Requesters: hold until acked, then drop or issue a fresh request
            for (int p = 0; p < 2; p++) begin
                if (req[p] && e_ack[p]) begin
                    if ($urandom_range(0, 1) == 0) req[p] = 1'b0;
                    else new_fields(p);
                end else if (!req[p] && $urandom_range(0, 99) < 40) begin
                    req[p] = 1'b1;
                    new_fields(p);
                end
            end

            // Slave: pready only at the chosen completion cycle inside ACCESS
            bus.tim_prdata  = $urandom;
            bus.tim_pslverr = ($urandom_range(0, 3) == 0);
            if (active && c >= g + 1 && c < ack_edge) begin
                bus.tim_pready = (w < TIMEOUT) && (c == g + 1 + w);
            end else begin
                bus.tim_pready = 1'($urandom_range(0, 1));
            end
            if (active && w < TIMEOUT && c == g + 1 + w) begin
                done_err   = bus.tim_pslverr;
                done_rdata = bus.tim_prdata;
            end

            // Occasional reset in the middle of an ACCESS phase
            rst_now = active && c >= g + 1 && c < ack_edge - 1 && ($urandom_range(0, 39) == 0);
            if (rst_now) begin
                for (int p = 0; p < 2; p++) begin
                    if (!req[p]) begin
                        req[p] = 1'b1;
                        new_fields(p);
                    end
                end
            end
            sys_rst = rst_now;

            // Grant decision taken at the coming edge
            if (!rst_now && (!active || c >= ack_edge)) begin
                el0 = req[0] && !e_ack[0];
                el1 = req[1] && !e_ack[1];
                if (el0 || el1) begin
                    if (el0 && el1) port = (last_gnt == 1) ? 0 : 1;
                    else            port = el0 ? 0 : 1;
                    last_gnt   = port;
                    active     = 1'b1;
                    g          = c + 1;
                    w          = $urandom_range(0, TIMEOUT + 1);
                    ack_edge   = (w < TIMEOUT) ? g + 2 + w : g + 1 + TIMEOUT;
                    t_write    = wr[port];
                    exp_fields = {wr[port], addr[port],
                                  wr[port] ? wdata[port] : 32'h0,
                                  wr[port] ? strb[port]  : 4'h0};
                end
            end
            rst_prev = rst_now;
        end

        check_val("port0 acked at least once", 64'(n_ack[0] > 0), 64'd1);
        check_val("port1 acked at least once", 64'(n_ack[1] > 0), 64'd1);
        check_val("timeout aborts seen",       64'(n_tmo > 0),    64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
